// File: rtl/iter_multdiv_unit_if.sv
// Execute-stage mult/div handshake: operands and start strobes in, result and completion pulse out.
interface iter_multdiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    // Pipeline side: issues operands and strobes, consumes the result.
    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    // Unit side: consumes operands and strobes, produces the result.
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/iter_multdiv_unit.sv
// Sequential signed multiply/divide: one magnitude shift-add or restoring-subtract
// step per cycle, followed by a single sign/exception fix-up cycle.
module iter_multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic               clock,
    input  logic               reset,
    iter_multdiv_unit_if.slave bus
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // Mult: {partial product high, multiplier shifting out}. Div: {remainder, dividend/quotient}.
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [WIDTH:0]   msum_c;
    logic [PW-1:0]    mul_step_c;
    logic [WIDTH:0]   rshift_c;
    logic [WIDTH-1:0] rdiff_c;
    logic             qbit_c;
    logic [PW-1:0]    div_step_c;
    logic [PW-1:0]    sprod_c;
    logic             mul_exc_c;
    logic [WIDTH-1:0] squot_c;
    logic             div_exc_c;

    // Datapath: operand magnitudes, one iteration step, and the signed fix-up values.
    always_comb begin
        start_c    = bus.ctrl_MULT ^ bus.ctrl_DIV;
        mag_a_c    = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        mag_b_c    = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
        msum_c     = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        mul_step_c = {msum_c, acc_q[WIDTH-1:1]};
        rshift_c   = acc_q[PW-1:WIDTH-1];
        qbit_c     = (rshift_c >= {1'b0, opb_q});
        rdiff_c    = WIDTH'(rshift_c - {1'b0, opb_q});
        div_step_c = {(qbit_c ? rdiff_c : rshift_c[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit_c};
        sprod_c    = neg_q ? -acc_q : acc_q;
        mul_exc_c  = (sprod_c[PW-1:WIDTH] != {WIDTH{sprod_c[WIDTH-1]}});
        squot_c    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Zero divisor, or a positive quotient of 2^(WIDTH-1) (most-negative / -1).
        div_exc_c  = (opb_q == '0) || (!neg_q && acc_q[WIDTH-1]);
    end

    // Next-state and register loads; a lone start strobe always wins and restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        if (start_c) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = bus.ctrl_DIV;
            neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            opb_d   = mag_b_c;
            acc_d   = {{WIDTH{1'b0}}, mag_a_c};
        end else begin
            unique case (state_q)
                RUN: begin
                    acc_d = div_q ? div_step_c : mul_step_c;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = FIX;
                end
                FIX: begin
                    rdy_d   = 1'b1;
                    state_d = DONE;
                    if (div_q) begin
                        res_d = div_exc_c ? '0 : squot_c;
                        exc_d = div_exc_c;
                    end else begin
                        res_d = sprod_c[WIDTH-1:0];
                        exc_d = mul_exc_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule
